// File: rtl/ts_pkg.sv
// Shared types and constants for the timestamp record packetizer.
// Record fields are held at their widest legal size; narrower instances zero-extend into them.
package ts_pkg;

    localparam int ID_W_MAX = 8;
    localparam int TS_W_MAX = 64;
    localparam logic [7:0] MAGIC = 8'hA5;

    function automatic int rec_bytes(input int ts_w);
        return 1 + 3 * (ts_w / 8);
    endfunction

    localparam int REC_BYTES = rec_bytes(TS_W_MAX);

    typedef enum logic [2:0] {
        IDLE,
        HDR_MAGIC,
        HDR_SEQ,
        REC,
        WAIT,
        TRAILER
    } pkt_state_e;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [TS_W_MAX-1:0] start_ts;
        logic [TS_W_MAX-1:0] end_ts;
        logic [TS_W_MAX-1:0] ts;
    } ts_record_t;

endpackage

// File: rtl/ts_idle_timer.sv
// Idle timer: counts enabled cycles after a clear and flags the last idle cycle.
// Latency: expired is combinational on the registered count.
// Backpressure: none; it saturates at the terminal count until cleared.
module ts_idle_timer #(
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(FLUSH_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/ts_record_packetizer.sv
// Serializes timestamp records big-endian into framed byte packets (header, records, count trailer).
// Latency: record captured at cycle t puts the first byte on m_tdata at t+1; one byte per clk max.
// Backpressure: output byte holds while !m_tready; upstream stalls via in_ready outside IDLE/WAIT.
module ts_record_packetizer
    import ts_pkg::*;
#(
    parameter int ID_W         = 4,
    parameter int TS_W         = 64,
    parameter int RECS_PER_PKT = 4,
    parameter int FLUSH_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [TS_W-1:0] in_start_ts,
    input  logic [TS_W-1:0] in_end_ts,
    input  logic [TS_W-1:0] in_ts,
    output logic [7:0]      m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic            pkt_done
);

    localparam int RB = rec_bytes(TS_W);
    localparam int IDX_W = $clog2(RB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RB - 1);
    localparam logic [7:0] FULL_CNT = 8'(RECS_PER_PKT);

    pkt_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, sel_idx;
    logic [7:0]       cnt_q, cnt_d, cnt_inc;
    logic [7:0]       seq_q, seq_d;
    logic [7:0]       tdata_q, tdata_d, next_byte;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic             run_q;
    ts_record_t       cap_q, cap_d, in_rec;
    logic [RB*8-1:0]  rec_flat;
    logic             pop, capture, timer_clr, timer_en, timer_exp;

    always_comb begin
        in_rec = '0;
        in_rec.id[ID_W-1:0]       = in_id;
        in_rec.start_ts[TS_W-1:0] = in_start_ts;
        in_rec.end_ts[TS_W-1:0]   = in_end_ts;
        in_rec.ts[TS_W-1:0]       = in_ts;
    end

    // Wire order of one record, MSB byte first; the mux picks the byte after the one on the bus.
    assign rec_flat = {cap_q.id, cap_q.start_ts[TS_W-1:0], cap_q.end_ts[TS_W-1:0], cap_q.ts[TS_W-1:0]};
    assign sel_idx  = idx_q + IDX_W'(1);

    always_comb begin
        next_byte = '0;
        for (int i = 0; i < RB; i++) begin
            if (sel_idx == IDX_W'(i)) next_byte = rec_flat[8*(RB-1-i) +: 8];
        end
    end

    assign in_ready = run_q && ((state_q == IDLE) || (state_q == WAIT));
    assign capture  = in_valid && in_ready;
    assign pop      = tvalid_q && m_tready;
    assign timer_en = (state_q == WAIT);
    assign cnt_inc  = cnt_q + 8'd1;

    ts_idle_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_exp)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        cap_d     = capture ? in_rec : cap_q;
        timer_clr = 1'b0;
        pkt_done  = 1'b0;
        case (state_q)
            IDLE: if (capture) begin
                state_d  = HDR_MAGIC;
                cnt_d    = '0;
                tvalid_d = 1'b1;
                tdata_d  = MAGIC;
                tlast_d  = 1'b0;
            end
            HDR_MAGIC: if (pop) begin
                state_d = HDR_SEQ;
                tdata_d = seq_q;
            end
            HDR_SEQ: if (pop) begin
                state_d = REC;
                idx_d   = '0;
                tdata_d = cap_q.id;
            end
            REC: if (pop) begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = sel_idx;
                    tdata_d = next_byte;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FULL_CNT) begin
                        state_d = TRAILER;
                        tdata_d = cnt_inc;
                        tlast_d = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        tvalid_d  = 1'b0;
                        timer_clr = 1'b1;
                    end
                end
            end
            // A record arriving on the expiry cycle keeps the packet open.
            WAIT: if (capture) begin
                state_d  = REC;
                idx_d    = '0;
                tvalid_d = 1'b1;
                tdata_d  = in_rec.id;
            end else if (timer_exp) begin
                state_d  = TRAILER;
                tvalid_d = 1'b1;
                tdata_d  = cnt_q;
                tlast_d  = 1'b1;
            end
            TRAILER: if (pop) begin
                state_d  = IDLE;
                pkt_done = 1'b1;
                seq_d    = seq_q + 8'd1;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            seq_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            cap_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            seq_q    <= seq_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            cap_q    <= cap_d;
            run_q    <= 1'b1;
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tvalid = tvalid_q;
    assign m_tlast  = tlast_q;

endmodule

// File: tb/tb_ts_record_packetizer.sv
// Bench for ts_record_packetizer: random records checked against a packet-level model of the framing.
module tb_ts_record_packetizer;

    localparam int FLUSH = 16;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] s;
        logic [63:0] e;
        logic [63:0] t;
    } rec_t;

    typedef struct {
        logic [8:0] b;
        int         cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_id = '0;
    logic [63:0] in_start_ts = '0;
    logic [63:0] in_end_ts = '0;
    logic [63:0] in_ts = '0;
    logic        m_tready = 1'b1;
    logic        in_ready, m_tvalid, m_tlast, pkt_done;
    logic [7:0]  m_tdata;

    bit          rnd_rdy = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_seq = '0;
    obs_t        got[$];
    logic [8:0]  exp_q[$];
    rec_t        pend[$];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_d;
    logic        prev_l;

    ts_record_packetizer #(
        .ID_W(4), .TS_W(64), .RECS_PER_PKT(4), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_ts(in_ts),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Collects accepted bytes and watches hold-under-stall and the pkt_done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                             m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
                end
            end
            if (pkt_done || (m_tvalid && m_tready && m_tlast)) begin
                n_cmp++;
                if (pkt_done !== (m_tvalid && m_tready && m_tlast)) begin
                    n_err++;
                    $display("FAIL pkt_done: got %b, want %b", pkt_done, m_tvalid && m_tready && m_tlast);
                end
            end
            if (m_tvalid && m_tready) got.push_back('{b: {m_tlast, m_tdata}, cyc: cyc});
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
    end

    function automatic rec_t rand_rec();
        rec_t r;
        r.id = 4'($urandom_range(0, 15));
        r.s  = {$urandom, $urandom};
        r.e  = r.s + 64'($urandom_range(0, 100000));
        r.t  = r.e - r.s;
        return r;
    endfunction

    // Expected frame: magic, seq, each pending record as id + three 8-byte fields MSB first, count.
    task automatic model_pkt(input logic [7:0] seq);
        logic [63:0] v;
        exp_q.push_back(9'h0A5);
        exp_q.push_back({1'b0, seq});
        foreach (pend[k]) begin
            exp_q.push_back({5'b0, pend[k].id});
            for (int f = 0; f < 3; f++) begin
                v = (f == 0) ? pend[k].s : (f == 1) ? pend[k].e : pend[k].t;
                for (int b = 7; b >= 0; b--) exp_q.push_back({1'b0, 8'(v >> (8 * b))});
            end
        end
        exp_q.push_back({1'b1, 8'(pend.size())});
        pend.delete();
    endtask

    task automatic push(input rec_t r, output int cap_cyc);
        int t;
        bit acc;
        in_valid = 1'b1; in_id = r.id; in_start_ts = r.s; in_end_ts = r.e; in_ts = r.t;
        t = 0; acc = 1'b0; cap_cyc = -1;
        while (!acc && t < 3000) begin
            @(negedge clk);
            acc = in_ready;
            cap_cyc = cyc;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL push_accept: in_ready stayed %b, want 1", acc);
        end
    endtask

    task automatic wait_bytes(input int n, input int extra);
        int t = 0;
        while (got.size() < n && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (extra) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        n_cmp++; if (m_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata: got %h want 00", m_tdata); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
        n_cmp++; if (pkt_done !== 1'b0) begin n_err++; $display("FAIL rst_pkt_done: got %b want 0", pkt_done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL run_gate: got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL run_set: got %b want 1", in_ready); end
        exp_seq = 8'h00;
    endtask

    task automatic test_single();
        rec_t r;
        int cap, bad;
        got.delete(); exp_q.delete();
        r.id = 4'd3; r.s = 64'h10; r.e = 64'h25; r.t = 64'h15;
        pend.push_back(r);
        push(r, cap);
        model_pkt(exp_seq); exp_seq++;
        wait_bytes(28, 30);
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i].b !== exp_q[i])) bad = i;
        if (bad < 0 && got.size() != exp_q.size()) bad = exp_q.size();
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL t1_bytes: at %0d got %0d bytes (0x%0h), want %0d bytes (0x%0h)", bad, got.size(),
                     (bad < got.size()) ? got[bad].b : 9'h0, exp_q.size(), (bad < exp_q.size()) ? exp_q[bad] : 9'h0);
        end
        if (got.size() >= 28) begin
            n_cmp++; if (got[2].b !== 9'h003) begin n_err++; $display("FAIL t1_id: got %h want 003", got[2].b); end
            n_cmp++; if (got[27].b !== 9'h101) begin n_err++; $display("FAIL t1_trailer: got %h want 101", got[27].b); end
            n_cmp++;
            if (got[0].cyc !== cap + 1) begin
                n_err++; $display("FAIL t1_latency: magic at cycle %0d, want %0d", got[0].cyc, cap + 1);
            end
            n_cmp++;
            if (got[27].cyc - got[26].cyc !== FLUSH + 1) begin
                n_err++; $display("FAIL t1_flush_gap: got %0d cycles want %0d", got[27].cyc - got[26].cyc, FLUSH + 1);
            end
        end
    endtask

    task automatic test_back_to_back(input bit rnd);
        rec_t r;
        int cap, bad, nl;
        got.delete(); exp_q.delete();
        rnd_rdy = rnd;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                r = rand_rec();
                pend.push_back(r);
                push(r, cap);
            end
            model_pkt(exp_seq); exp_seq++;
        end
        wait_bytes(206, 30);
        rnd_rdy = 1'b0;
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i].b !== exp_q[i])) bad = i;
        if (bad < 0 && got.size() != exp_q.size()) bad = exp_q.size();
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL b2b_bytes(rnd=%0d): at %0d got %0d bytes (0x%0h), want %0d bytes (0x%0h)", rnd, bad,
                     got.size(), (bad < got.size()) ? got[bad].b : 9'h0, exp_q.size(),
                     (bad < exp_q.size()) ? exp_q[bad] : 9'h0);
        end
        nl = 0;
        foreach (got[i]) if (got[i].b[8]) nl++;
        n_cmp++;
        if (nl !== 2 || got.size() < 206 || !got[102].b[8] || !got[205].b[8]) begin
            n_err++; $display("FAIL b2b_tlast(rnd=%0d): got %0d lasts, want 2 at bytes 103 and 206", rnd, nl);
        end
    endtask

    task automatic test_seq_wrap();
        rec_t r;
        int cap, bad;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 exp_seq = 8'h00;
        for (int p = 1; p <= 257; p++) begin
            got.delete(); exp_q.delete();
            r = rand_rec();
            pend.push_back(r);
            push(r, cap);
            model_pkt(exp_seq); exp_seq++;
            wait_bytes(28, 0);
            bad = -1;
            foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i].b !== exp_q[i])) bad = i;
            if (bad < 0 && got.size() != exp_q.size()) bad = exp_q.size();
            n_cmp++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL wrap_pkt%0d: at %0d got 0x%0h, want 0x%0h", p, bad,
                         (bad < got.size()) ? got[bad].b : 9'h0, (bad < exp_q.size()) ? exp_q[bad] : 9'h0);
            end
            if (p >= 256 && got.size() > 1) begin
                n_cmp++;
                if (got[1].b !== ((p == 256) ? 9'h0FF : 9'h000)) begin
                    n_err++; $display("FAIL wrap_seq%0d: got %h want %h", p, got[1].b, (p == 256) ? 9'h0FF : 9'h000);
                end
            end
        end
    endtask

    task automatic test_timeout_race();
        rec_t r;
        int cap, bad, n, t;
        got.delete(); exp_q.delete();
        r = rand_rec(); pend.push_back(r);
        push(r, cap);
        wait_bytes(27, 0);
        n = (got.size() >= 27) ? got[26].cyc : cyc;
        t = 0;
        while (cyc < n + FLUSH && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        r = rand_rec(); pend.push_back(r);
        push(r, cap);
        n_cmp++;
        if (cap !== n + FLUSH) begin
            n_err++; $display("FAIL race_capture: captured at cycle %0d, want %0d", cap, n + FLUSH);
        end
        model_pkt(exp_seq); exp_seq++;
        wait_bytes(53, 30);
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i].b !== exp_q[i])) bad = i;
        if (bad < 0 && got.size() != exp_q.size()) bad = exp_q.size();
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL race_bytes: at %0d got %0d bytes (0x%0h), want %0d bytes (0x%0h)", bad, got.size(),
                     (bad < got.size()) ? got[bad].b : 9'h0, exp_q.size(), (bad < exp_q.size()) ? exp_q[bad] : 9'h0);
        end
        if (got.size() >= 53) begin
            n_cmp++; if (got[52].b !== 9'h102) begin n_err++; $display("FAIL race_count: got %h want 102", got[52].b); end
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        int cap, bad;
        got.delete(); exp_q.delete();
        for (int k = 0; k < 2; k++) begin
            r = rand_rec();
            push(r, cap);
        end
        wait_bytes(40, 0);
        n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", m_tvalid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_tvalid_drop: got %b want 0", m_tvalid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_run_gate: got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_run_set: got %b want 1", in_ready); end
        got.delete(); exp_q.delete();
        exp_seq = 8'h00;
        r = rand_rec(); pend.push_back(r);
        push(r, cap);
        model_pkt(exp_seq); exp_seq++;
        wait_bytes(28, 30);
        bad = -1;
        foreach (exp_q[i]) if (bad < 0 && (i >= got.size() || got[i].b !== exp_q[i])) bad = i;
        if (bad < 0 && got.size() != exp_q.size()) bad = exp_q.size();
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL mid_next_pkt: at %0d got %0d bytes (0x%0h), want %0d bytes (0x%0h)", bad, got.size(),
                     (bad < got.size()) ? got[bad].b : 9'h0, exp_q.size(), (bad < exp_q.size()) ? exp_q[bad] : 9'h0);
        end
        if (got.size() >= 2) begin
            n_cmp++;
            if (got[0].b !== 9'h0A5 || got[1].b !== 9'h000) begin
                n_err++; $display("FAIL mid_header: got %h %h want 0a5 000", got[0].b, got[1].b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_seq_wrap();
        test_timeout_race();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
